k005297_sumseq: RTL and testbench

- Sequencer for the page-checksum datapath: the serial adder accumulator, the constant/checksum shift register and the equality comparator.
- For each page it clears the accumulator and counts payload bits into the serial adder. It then shifts the stored checksum field into the constant register, runs the bit-serial compare window and reports a pass or fail.
- On fail it requests a re-read, up to a retry limit.
- Sits between the page-read timing logic and the sum/compare datapath. It drives the datapath shift and clear strobes and consumes the active-low equal flag.

---
 rtl/k005297_sumseq_if.sv | 43 ++++
 rtl/k005297_sumseq.sv | 170 +++++++++++++++++
 tb/tb_k005297_sumseq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/k005297_sumseq_if.sv
// Handshake/strobe bundle between the page-read timing logic and the checksum sequencer.
// The err_total/errstat_clr pair exists only with K005297_SUMSEQ_ERRSTAT_EN.
interface k005297_sumseq_if;
  logic       clk2m_pcen_n;
  logic       page_start;
  logic       bdi_valid;
  logic       abort;
  logic       sumeq_n;
  logic       sum_clr;
  logic       var_shift;
  logic       const_load;
  logic       cmp_rst_n;
  logic       busy;
  logic       page_ok;
  logic       page_err;
  logic       retry_req;
  logic [1:0] retry_cnt;
`ifdef K005297_SUMSEQ_ERRSTAT_EN
  logic       errstat_clr;
  logic [7:0] err_total;
`endif

  // master: page-read timing side, which drives the sequencer inputs
  modport master (
`ifdef K005297_SUMSEQ_ERRSTAT_EN
    output errstat_clr,
    input  err_total,
`endif
    output clk2m_pcen_n, page_start, bdi_valid, abort, sumeq_n,
    input  sum_clr, var_shift, const_load, cmp_rst_n, busy,
    input  page_ok, page_err, retry_req, retry_cnt
  );

  modport slave (
`ifdef K005297_SUMSEQ_ERRSTAT_EN
    input  errstat_clr,
    output err_total,
`endif
    input  clk2m_pcen_n, page_start, bdi_valid, abort, sumeq_n,
    output sum_clr, var_shift, const_load, cmp_rst_n, busy,
    output page_ok, page_err, retry_req, retry_cnt
  );
endinterface

// File: rtl/k005297_sumseq.sv
// Page-checksum sequencer: accumulate payload, shift in stored checksum, compare, retry.
// Define K005297_SUMSEQ_ERRSTAT_EN to add the saturating error-total counter.
module k005297_sumseq #(
  parameter int unsigned PAGE_BITS = 512,
  parameter int unsigned SUM_BITS  = 12,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned CNT_W     = 10
) (
  input  logic               i_MCLK,
  input  logic               i_RST,
  k005297_sumseq_if.slave    bus
);

  localparam logic [CNT_W-1:0] PAGE_LAST = CNT_W'(PAGE_BITS - 1);
  localparam logic [CNT_W-1:0] SUM_LAST  = CNT_W'(SUM_BITS - 1);
  localparam logic [CNT_W-1:0] CMP_LAST  = CNT_W'(SUM_BITS);
  localparam logic [1:0]       RETRY_LIM = 2'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, LOADK, CMP, JUDGE, WAITRD} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       retry_cnt, retry_cnt_nx;
  logic             tick, abort_hit;
  logic             ok_set, err_set, retry_set;
  logic             ok_q, err_q, retry_q;
  logic             sum_clr, var_shift, const_load, cmp_rst_n, busy;

  assign tick      = ~bus.clk2m_pcen_n;
  assign abort_hit = bus.abort && (state != IDLE);

  // State register
  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST)     state <= IDLE;
    else if (tick) state <= state_nx;
  end

  // Next state, bit counter and judge outcome
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    retry_cnt_nx = retry_cnt;
    ok_set       = 1'b0;
    err_set      = 1'b0;
    retry_set    = 1'b0;
    case (state)
      IDLE: if (bus.page_start) begin
        state_nx     = CLEAR;
        retry_cnt_nx = 2'd0;
      end
      CLEAR: begin
        cnt_nx   = '0;
        state_nx = ACCUM;
      end
      ACCUM: if (bus.bdi_valid) begin
        if (cnt == PAGE_LAST) begin
          cnt_nx   = '0;
          state_nx = LOADK;
        end else cnt_nx = cnt + CNT_W'(1);
      end
      LOADK: if (bus.bdi_valid) begin
        if (cnt == SUM_LAST) begin
          cnt_nx   = '0;
          state_nx = CMP;
        end else cnt_nx = cnt + CNT_W'(1);
      end
      // One re-arm tick followed by SUM_BITS compare ticks
      CMP: begin
        if (cnt == CMP_LAST) begin
          cnt_nx   = '0;
          state_nx = JUDGE;
        end else cnt_nx = cnt + CNT_W'(1);
      end
      JUDGE: begin
        if (!bus.sumeq_n) begin
          ok_set   = 1'b1;
          state_nx = IDLE;
        end else if (retry_cnt < RETRY_LIM) begin
          retry_set    = 1'b1;
          retry_cnt_nx = (retry_cnt == 2'd3) ? retry_cnt : retry_cnt + 2'd1;
          state_nx     = WAITRD;
        end else begin
          err_set  = 1'b1;
          state_nx = IDLE;
        end
      end
      WAITRD: if (bus.page_start) state_nx = CLEAR;
      default: state_nx = IDLE;
    endcase
    // Abort overrides every transition, including a passing judge
    if (abort_hit) begin
      state_nx     = IDLE;
      cnt_nx       = '0;
      retry_cnt_nx = retry_cnt;
      ok_set       = 1'b0;
      retry_set    = 1'b0;
      err_set      = 1'b1;
    end
  end

  // Datapath strobes, combinational from state and inputs
  always_comb begin
    sum_clr    = 1'b0;
    var_shift  = 1'b0;
    const_load = 1'b0;
    cmp_rst_n  = 1'b1;
    busy       = (state != IDLE);
    case (state)
      CLEAR: begin
        sum_clr   = 1'b1;
        cmp_rst_n = 1'b0;
      end
      ACCUM: var_shift = bus.bdi_valid;
      LOADK: begin
        var_shift  = bus.bdi_valid;
        const_load = bus.bdi_valid;
      end
      CMP:     cmp_rst_n = (cnt != '0);
      default: ;
    endcase
    if (abort_hit) begin
      sum_clr    = 1'b1;
      var_shift  = 1'b0;
      const_load = 1'b0;
    end
  end

  // Counters and one-tick result pulses
  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      cnt       <= '0;
      retry_cnt <= 2'd0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      retry_q   <= 1'b0;
    end else if (tick) begin
      cnt       <= cnt_nx;
      retry_cnt <= retry_cnt_nx;
      ok_q      <= ok_set;
      err_q     <= err_set;
      retry_q   <= retry_set;
    end
  end

  assign bus.sum_clr    = sum_clr;
  assign bus.var_shift  = var_shift;
  assign bus.const_load = const_load;
  assign bus.cmp_rst_n  = cmp_rst_n;
  assign bus.busy       = busy;
  assign bus.page_ok    = ok_q;
  assign bus.page_err   = err_q;
  assign bus.retry_req  = retry_q;
  assign bus.retry_cnt  = retry_cnt;

`ifdef K005297_SUMSEQ_ERRSTAT_EN
  logic [7:0] err_total;

  // Saturating count of error pulses; a clear coinciding with an error leaves 1
  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) err_total <= 8'd0;
    else if (tick) begin
      if (bus.errstat_clr)                     err_total <= 8'(err_set);
      else if (err_set && err_total != 8'hFF)  err_total <= err_total + 8'd1;
    end
  end

  assign bus.err_total = err_total;
`endif

endmodule

// File: tb/tb_k005297_sumseq.sv
// Randomized scoreboard bench for k005297_sumseq; honours K005297_SUMSEQ_ERRSTAT_EN when defined.
module tb_k005297_sumseq;
  localparam int P  = 512;
  localparam int S  = 12;
  localparam int MR = 3;

  localparam int K_OK    = 0;
  localparam int K_ERR   = 1;
  localparam int K_RETRY = 2;

  localparam int M_NORMAL      = 0;
  localparam int M_ABORT_CLEAR = 1;
  localparam int M_ABORT_DATA  = 2;
  localparam int M_ABORT_JUDGE = 3;
  localparam int M_RST         = 4;

  typedef struct {
    int kind;
    int tick;
    int rc;
    int var_n;
    int const_n;
    int clr_n;
    int cmp_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   tick_no = 0;
  logic tick_edge = 1'b0;
  int   n_var, n_const, n_clr, n_cmp;
  exp_t sb[$];
`ifdef K005297_SUMSEQ_ERRSTAT_EN
  logic clr_req = 1'b0;
`endif

  always #5 clk = ~clk;

  k005297_sumseq_if bus();

  k005297_sumseq #(
    .PAGE_BITS (P),
    .SUM_BITS  (S),
    .MAX_RETRY (MR),
    .CNT_W     (10)
  ) dut (
    .i_MCLK (clk),
    .i_RST  (rst),
    .bus    (bus)
  );

  initial assert (MR <= 3) else $error("MAX_RETRY above 3 cannot be reported on a 2-bit retry count");

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tick %0d)", name, act, exp, tick_no);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Random non-tick cycles carrying garbage, then one enabled tick with the given inputs
  task automatic tick(input logic st, input logic v, input logic ab, input logic sq);
    while ($urandom_range(0, 3) == 0) begin
      bus.clk2m_pcen_n = 1'b1;
      bus.page_start   = rb();
      bus.bdi_valid    = rb();
      bus.abort        = rb();
      bus.sumeq_n      = rb();
`ifdef K005297_SUMSEQ_ERRSTAT_EN
      bus.errstat_clr  = rb();
`endif
      @(posedge clk); #1;
    end
    bus.clk2m_pcen_n = 1'b0;
    bus.page_start   = st;
    bus.bdi_valid    = v;
    bus.abort        = ab;
    bus.sumeq_n      = sq;
`ifdef K005297_SUMSEQ_ERRSTAT_EN
    bus.errstat_clr  = clr_req;
`endif
    @(posedge clk); #1;
  endtask

  // One read attempt; the expected outcome is queued from the page rules before it happens
  task automatic run_attempt(input int mode, input bit gap, input int at_n, input int rc,
                             input bit pass, output bit retried);
    int   n, ph, t_last;
    logic v;
    exp_t e;
    retried = 1'b0;
    tick(1'b1, rb(), 1'b0, rb());
    if (mode == M_ABORT_CLEAR) begin
      e = '{K_ERR, tick_no + 1, rc, 0, 0, 1, 1};
      sb.push_back(e);
      tick(rb(), rb(), 1'b1, rb());
      return;
    end
    tick(rb(), rb(), 1'b0, rb());
    n  = 0;
    ph = 0;
    while (n < P + S) begin
      v = (!gap || (ph % 3 != 2));
      ph++;
      if (mode == M_ABORT_DATA && n == at_n) begin
        e = '{K_ERR, tick_no + 1, rc, n, (n > P) ? n - P : 0, 2, 1};
        sb.push_back(e);
        tick(rb(), 1'b1, 1'b1, rb());
        return;
      end
      if (mode == M_RST && n == at_n) begin
        bus.clk2m_pcen_n = 1'b1;
        bus.bdi_valid    = 1'b1;
        bus.abort        = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_busy",       int'(bus.busy),       0);
        chk("rst_var_shift",  int'(bus.var_shift),  0);
        chk("rst_sum_clr",    int'(bus.sum_clr),    0);
        chk("rst_cmp_rst_n",  int'(bus.cmp_rst_n),  1);
        chk("rst_page_ok",    int'(bus.page_ok),    0);
        chk("rst_page_err",   int'(bus.page_err),   0);
        chk("rst_retry_cnt",  int'(bus.retry_cnt),  0);
        #6 rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      tick(rb(), v, 1'b0, rb());
      if (v) n++;
    end
    t_last = tick_no;
    if (mode == M_ABORT_JUDGE)  e = '{K_ERR,   t_last + S + 2, rc,     P + S, S, 2, 2};
    else if (pass)              e = '{K_OK,    t_last + S + 2, rc,     P + S, S, 1, 2};
    else if (rc < MR) begin
      e = '{K_RETRY, t_last + S + 2, rc + 1, P + S, S, 1, 2};
      retried = 1'b1;
    end else                    e = '{K_ERR,   t_last + S + 2, rc,     P + S, S, 1, 2};
    sb.push_back(e);
    repeat (S + 1) tick(rb(), rb(), 1'b0, rb());
    tick(1'b0, rb(), (mode == M_ABORT_JUDGE), !pass);
  endtask

  // Full page with the first 'fails' attempts failing the compare
  task automatic run_page(input int fails, input bit gap);
    bit r;
    int rc;
    rc = 0;
    r  = 1'b1;
    while (r) begin
      run_attempt(M_NORMAL, gap, 0, rc, (rc >= fails), r);
      if (r) begin
        rc++;
        repeat ($urandom_range(0, 4)) tick(1'b0, rb(), 1'b0, rb());
      end
    end
    repeat ($urandom_range(1, 4)) tick(1'b0, rb(), rb(), rb());
  endtask

  // Tick bookkeeping at the active edge
  initial forever begin
    @(posedge clk);
    tick_edge = !rst && !bus.clk2m_pcen_n;
    if (tick_edge) tick_no++;
  end

  // Monitor: pop and compare on every result pulse; accumulate strobes at ticks
  initial begin
    int   ok, er, rq, kind;
    exp_t e;
    n_var = 0; n_const = 0; n_clr = 0; n_cmp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_var = 0; n_const = 0; n_clr = 0; n_cmp = 0;
      end else begin
        ok = int'(bus.page_ok);
        er = int'(bus.page_err);
        rq = int'(bus.retry_req);
        if (tick_edge && (ok + er + rq) != 0) begin
          kind = (er != 0) ? K_ERR : ((rq != 0) ? K_RETRY : K_OK);
          chk("single_pulse", ok + er + rq, 1);
          if (sb.size() == 0) chk("unexpected_pulse_kind", kind, -1);
          else begin
            e = sb.pop_front();
            chk("result_kind",    kind,                 e.kind);
            chk("result_tick",    tick_no,              e.tick);
            chk("retry_cnt",      int'(bus.retry_cnt),  e.rc);
            chk("busy_at_result", int'(bus.busy),       (e.kind == K_RETRY) ? 1 : 0);
            chk("var_shift_ticks",  n_var,   e.var_n);
            chk("const_load_ticks", n_const, e.const_n);
            chk("sum_clr_ticks",    n_clr,   e.clr_n);
            chk("cmp_rearm_ticks",  n_cmp,   e.cmp_n);
          end
          n_var = 0; n_const = 0; n_clr = 0; n_cmp = 0;
        end
        if (!bus.clk2m_pcen_n) begin
          n_var   += int'(bus.var_shift);
          n_const += int'(bus.const_load);
          n_clr   += int'(bus.sum_clr);
          n_cmp   += int'(!bus.cmp_rst_n);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached with %0d results pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bit r;
`ifdef K005297_SUMSEQ_ERRSTAT_EN
    exp_t e;
    bus.errstat_clr = 1'b0;
`endif
    rst = 1'b1;
    bus.clk2m_pcen_n = 1'b0;
    bus.page_start   = 1'b1;
    bus.bdi_valid    = 1'b1;
    bus.abort        = 1'b0;
    bus.sumeq_n      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",       int'(bus.busy),       0);
    chk("reset_sum_clr",    int'(bus.sum_clr),    0);
    chk("reset_var_shift",  int'(bus.var_shift),  0);
    chk("reset_const_load", int'(bus.const_load), 0);
    chk("reset_cmp_rst_n",  int'(bus.cmp_rst_n),  1);
    chk("reset_page_ok",    int'(bus.page_ok),    0);
    chk("reset_page_err",   int'(bus.page_err),   0);
    chk("reset_retry_req",  int'(bus.retry_req),  0);
    chk("reset_retry_cnt",  int'(bus.retry_cnt),  0);
    bus.page_start = 1'b0;
    rst = 1'b0;
    repeat (2) tick(1'b0, rb(), rb(), rb());

    run_page(0, 1'b0);
    run_page(MR + 1, 1'b0);
    run_page(1, 1'b1);

    run_attempt(M_ABORT_DATA, 1'b0, P + 5, 0, 1'b1, r);
    repeat (2) tick(1'b0, rb(), 1'b0, rb());
    run_attempt(M_ABORT_DATA, 1'b1, 100, 0, 1'b1, r);
    repeat (2) tick(1'b0, rb(), 1'b0, rb());

    run_attempt(M_NORMAL, 1'b0, 0, 0, 1'b0, r);
    if (r) repeat (2) tick(1'b0, rb(), 1'b0, rb());
    run_attempt(M_ABORT_DATA, 1'b0, 37, 1, 1'b1, r);
    repeat (2) tick(1'b0, rb(), 1'b0, rb());

    run_attempt(M_ABORT_JUDGE, 1'b0, 0, 0, 1'b1, r);
    repeat (2) tick(1'b0, rb(), 1'b0, rb());
    run_attempt(M_ABORT_CLEAR, 1'b0, 0, 0, 1'b1, r);
    repeat (2) tick(1'b0, rb(), 1'b0, rb());

    run_attempt(M_RST, 1'b1, 200, 0, 1'b1, r);
    run_page(0, 1'b0);
    run_page(2, 1'b1);

`ifdef K005297_SUMSEQ_ERRSTAT_EN
    clr_req = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    clr_req = 1'b0;
    chk("err_total_clr", int'(bus.err_total), 0);
    repeat (257) begin
      run_attempt(M_ABORT_CLEAR, 1'b0, 0, 0, 1'b1, r);
      tick(1'b0, rb(), 1'b0, rb());
    end
    chk("err_total_sat", int'(bus.err_total), 255);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    e = '{K_ERR, tick_no + 1, 0, 0, 0, 1, 1};
    sb.push_back(e);
    clr_req = 1'b1;
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    clr_req = 1'b0;
    chk("err_total_clr_with_err", int'(bus.err_total), 1);
`endif

    repeat (5) tick(1'b0, rb(), rb(), rb());
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
